// File: rtl/toggle_pulse_decoder_pkg.sv
// Shared default sizing for the toggle pulse decoder and its synchronizer.
package toggle_dec_pkg;

    localparam int unsigned DEF_INPUT_WIDTH = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_WIDTH   = 8;

endpackage : toggle_dec_pkg

// File: rtl/toggle_pulse_decoder_sync.sv
// Single-bit multi-flop synchronizer; plain flop chain with nothing between stages.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/toggle_pulse_decoder.sv
// Decodes remote toggle-flop levels into one-cycle pulses and a pending-event bitmap
// with ready/valid acceptance, sticky overflow flags and an accepted-handshake counter.
module toggle_pulse_decoder
    import toggle_dec_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [INPUT_WIDTH-1:0] t_in,
    output logic [INPUT_WIDTH-1:0] pulse,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [INPUT_WIDTH-1:0] evt_vec,
    output logic [INPUT_WIDTH-1:0] ovf,
    input  logic                   ovf_clr,
    output logic [CNT_WIDTH-1:0]   evt_count
);

    logic [INPUT_WIDTH-1:0] sync_out;
    logic [INPUT_WIDTH-1:0] last;
    logic [INPUT_WIDTH-1:0] pend;
    logic [INPUT_WIDTH-1:0] acc_mask;
    logic [INPUT_WIDTH-1:0] ovf_set;
    logic                   accept;

    for (genvar i = 0; i < INPUT_WIDTH; i++) begin : g_sync
        bit_synchronizer #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d    (t_in[i]),
            .q    (sync_out[i])
        );
    end

    // last resets to 0, so inputs already high at release yield one pulse each
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last  <= '0;
            pulse <= '0;
        end else begin
            last  <= sync_out;
            pulse <= sync_out ^ last;
        end
    end

    always_comb begin
        accept   = evt_valid && evt_ready;
        acc_mask = accept ? pend : '0;
        ovf_set  = pulse & pend & ~acc_mask;
    end

    // A pulse landing on a bit being accepted re-arms it, so no event is lost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend      <= '0;
            ovf       <= '0;
            evt_count <= '0;
        end else begin
            pend <= (pend & ~acc_mask) | pulse;
            ovf  <= (ovf_clr ? '0 : ovf) | ovf_set;
            if (accept) begin
                evt_count <= evt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign evt_vec   = pend;
    assign evt_valid = |pend;

endmodule : toggle_pulse_decoder
